// File: rtl/tlb_pkg.sv
// Shared TLB constants, page-table-walk FSM states and the fill payload.
// Geometry defaults are also used by the TLB set array.
package tlb_pkg;

    localparam int unsigned ADDR   = 64;
    localparam int unsigned PAGE   = 12;
    localparam int unsigned PCID_B = 12;
    localparam int unsigned LEVELS = 4;
    localparam int unsigned IDX_B  = 9;

    localparam int unsigned VPN_B  = ADDR - PAGE;
    localparam int unsigned LVL_B  = (LEVELS > 1) ? $clog2(LEVELS) : 1;
    localparam int unsigned PTE_SH = $clog2(ADDR / 8);

    localparam int unsigned PTE_V  = 0;
    localparam int unsigned PTE_L  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_FILL = 2'd3
    } walk_state_e;

    typedef struct packed {
        logic [VPN_B-1:0]  va_page;
        logic [PCID_B-1:0] pcid;
        logic [VPN_B-1:0]  ppn;
        logic [LVL_B-1:0]  level;
        logic              fault;
    } fill_t;

endpackage

// File: rtl/tlb_walker_addr.sv
// Per-level PTE address generation and superpage PPN merge (combinational).
module tlb_walker_addr
    import tlb_pkg::*;
(
    input  logic [VPN_B-1:0] i_va_page,
    input  logic [VPN_B-1:0] i_tbl_ppn,
    input  logic [LVL_B-1:0] i_lvl,
    input  logic [VPN_B-1:0] i_pte_ppn,
    output logic [ADDR-1:0]  o_pte_addr,
    output logic [VPN_B-1:0] o_leaf_ppn
);

    logic [IDX_B-1:0] w_idx;
    logic [VPN_B-1:0] w_low_mask;

    assign w_idx      = IDX_B'(i_va_page >> (IDX_B * i_lvl));
    assign o_pte_addr = {i_tbl_ppn, PAGE'(0)} + (ADDR'(w_idx) << PTE_SH);

    // Superpage leaves take their low lvl*IDX_B PPN bits from the VA.
    assign w_low_mask = ~({VPN_B{1'b1}} << (IDX_B * i_lvl));
    assign o_leaf_ppn = (i_pte_ppn & ~w_low_mask) | (i_va_page & w_low_mask);

endmodule

// File: rtl/tlb_walker.sv
// Radix page-table walker: one miss in, PTE reads out, fill/fault back to the TLB.
// Define TLBW_STATS_EN to add the stat_walks / stat_faults counters.
module tlb_walker
    import tlb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_valid,
    output logic              miss_ready,
    input  logic [ADDR-1:0]   miss_va,
    input  logic [PCID_B-1:0] miss_pcid,
    input  logic [VPN_B-1:0]  ptbr_ppn,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR-1:0]   mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [ADDR-1:0]   mem_rsp_data,
    output logic              fill_valid,
    input  logic              fill_ready,
    output logic [VPN_B-1:0]  fill_va_page,
    output logic [PCID_B-1:0] fill_pcid,
    output logic [VPN_B-1:0]  fill_ppn,
    output logic [LVL_B-1:0]  fill_level,
    output logic              fill_fault
`ifdef TLBW_STATS_EN
    ,
    output logic [31:0]       stat_walks,
    output logic [31:0]       stat_faults
`endif
);

    walk_state_e       r_state, w_state_nxt;
    logic [VPN_B-1:0]  r_va, w_va_nxt;
    logic [VPN_B-1:0]  r_tbl, w_tbl_nxt;
    logic [LVL_B-1:0]  r_lvl, w_lvl_nxt;
    logic [PCID_B-1:0] r_pcid;
    logic              r_miss_ready, r_req_valid, r_fill_valid;
    logic [ADDR-1:0]   r_req_addr;
    fill_t             r_fill;

    logic              w_accept, w_leaf, w_fault;
    logic              w_pte_v, w_pte_l;
    logic [VPN_B-1:0]  w_pte_ppn, w_leaf_ppn;
    logic [ADDR-1:0]   w_pte_addr;
    logic              w_unused;

    assign w_pte_v   = mem_rsp_data[PTE_V];
    assign w_pte_l   = mem_rsp_data[PTE_L];
    assign w_pte_ppn = mem_rsp_data[ADDR-1:PAGE];
    assign w_unused  = ^{mem_rsp_data[PAGE-1:2], miss_va[PAGE-1:0]};

    // Address unit sees the next-cycle walk context so the request address is registered.
    tlb_walker_addr u_addr (
        .i_va_page  (w_va_nxt),
        .i_tbl_ppn  (w_tbl_nxt),
        .i_lvl      (w_lvl_nxt),
        .i_pte_ppn  (w_pte_ppn),
        .o_pte_addr (w_pte_addr),
        .o_leaf_ppn (w_leaf_ppn)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_va_nxt    = r_va;
        w_tbl_nxt   = r_tbl;
        w_lvl_nxt   = r_lvl;
        w_accept    = 1'b0;
        w_leaf      = 1'b0;
        w_fault     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (miss_valid) begin
                    w_accept    = 1'b1;
                    w_va_nxt    = miss_va[ADDR-1:PAGE];
                    w_tbl_nxt   = ptbr_ppn;
                    w_lvl_nxt   = LVL_B'(LEVELS - 1);
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    if (!w_pte_v) begin
                        w_fault     = 1'b1;
                        w_state_nxt = ST_FILL;
                    end else if (w_pte_l) begin
                        w_leaf      = 1'b1;
                        w_state_nxt = ST_FILL;
                    end else if (r_lvl != '0) begin
                        w_tbl_nxt   = w_pte_ppn;
                        w_lvl_nxt   = r_lvl - LVL_B'(1);
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_fault     = 1'b1;
                        w_state_nxt = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (fill_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_va         <= '0;
            r_tbl        <= '0;
            r_lvl        <= '0;
            r_pcid       <= '0;
            r_miss_ready <= 1'b1;
            r_req_valid  <= 1'b0;
            r_fill_valid <= 1'b0;
            r_req_addr   <= '0;
            r_fill       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_va         <= w_va_nxt;
            r_tbl        <= w_tbl_nxt;
            r_lvl        <= w_lvl_nxt;
            r_miss_ready <= (w_state_nxt == ST_IDLE);
            r_req_valid  <= (w_state_nxt == ST_REQ);
            r_fill_valid <= (w_state_nxt == ST_FILL);
            if (w_accept) r_pcid <= miss_pcid;
            if (w_state_nxt == ST_REQ && r_state != ST_REQ) r_req_addr <= w_pte_addr;
            if (w_leaf || w_fault) begin
                r_fill.va_page <= r_va;
                r_fill.pcid    <= r_pcid;
                r_fill.ppn     <= w_leaf ? w_leaf_ppn : '0;
                r_fill.level   <= w_leaf ? r_lvl : '0;
                r_fill.fault   <= w_fault;
            end
        end
    end

`ifdef TLBW_STATS_EN
    logic [31:0] r_stat_walks, r_stat_faults;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_walks  <= '0;
            r_stat_faults <= '0;
        end else begin
            if (w_accept) r_stat_walks <= r_stat_walks + 32'd1;
            if (r_state == ST_FILL && fill_ready && r_fill.fault)
                r_stat_faults <= r_stat_faults + 32'd1;
        end
    end

    assign stat_walks  = r_stat_walks;
    assign stat_faults = r_stat_faults;
`endif

    assign miss_ready    = r_miss_ready;
    assign mem_req_valid = r_req_valid;
    assign mem_req_addr  = r_req_addr;
    assign fill_valid    = r_fill_valid;
    assign fill_va_page  = r_fill.va_page;
    assign fill_pcid     = r_fill.pcid;
    assign fill_ppn      = r_fill.ppn;
    assign fill_level    = r_fill.level;
    assign fill_fault    = r_fill.fault;

endmodule
